johnson_phase_monitor: RTL and testbench
========================================

// Module: johnson_phase_monitor
// PURPOSE
//  Downstream consumer of the 4-bit Johnson counter (cnt bus). Samples the code every clk,
//  decodes it to a phase index and one-hot phase strobe, checks code legality and step order,
//  runs a lock FSM, and keeps revolution and error counters. Feeds phase sequencing logic.
// PARAMETERS
//  W        4  Johnson width; 2*W states; PW=$clog2(2*W) phase bits
//  LOCK_CNT 4  consecutive good transitions needed to assert locked (>=1)
//  REVW     8  revolution counter width (wraps)
//  ERRW     4  error counter width (saturates)
// PORTS
//  clk      in   1     clock, rising edge
//  rst      in   1     synchronous, active-high reset
//  cnt      in   W     Johnson code from upstream counter
//  clr_err  in   1     synchronous clear of err_cnt
//  phase    out  PW    decoded phase index (0..2W-1)
//  phase_oh out  2W    one-hot phase; bit[phase] set, all 0 on illegal code
//  code_err out  1     1-cycle pulse: sampled code illegal
//  seq_err  out  1     1-cycle pulse: legal code but not successor/hold of previous
//  wrap     out  1     1-cycle pulse: good transition phase 2W-1 -> 0
//  locked   out  1     lock FSM in LOCK
//  rev_cnt  out  REVW  count of wrap pulses, modulo 2^REVW
//  err_cnt  out  ERRW  count of error cycles, saturating at all-ones
// BEHAVIOUR
//  - Upstream sequence: next = {cnt[W-2:0], ~cnt[W-1]}; W=4: 0000,0001,0011,0111,1111,1110,1100,1000.
//  - Legal: msb=0 and ones contiguous from LSB -> phase=popcount; msb=1 and zeros contiguous
//    from LSB -> phase=W+number of zeros. Anything else illegal.
//  - Latency: all outputs registered; cnt sampled on edge E is reflected on outputs after E.
//  - Reset (rst=1 at edge): every output 0, FSM=UNLOCK, run=0, prev_valid=0.
//  - Internal prev code/prev_valid updated on every legal sample; illegal sample clears prev_valid.
//  - Transition classes (only when prev_valid and current legal):
//    good = current is successor of prev; hold = current==prev; else seq_err.
//    First legal sample after reset/illegal: no check, no error.
//  - Hold is neutral: no error, run unchanged, locked unchanged (upstream held in reset is OK).
//  - err event = code_err|seq_err (never both same cycle; illegal -> code_err only).
//  - Lock FSM (run counter 0..LOCK_CNT):
//    UNLOCK: legal sample -> ACQ, run=0; illegal -> stay.
//    ACQ: good -> run+1; if run+1==LOCK_CNT -> LOCK; hold -> stay; err -> UNLOCK, run=0.
//    LOCK: good/hold -> stay; err -> UNLOCK, run=0, locked falls on same edge.
//  - wrap: good transition 2W-1 -> 0, any FSM state; rev_cnt+1 same edge, wraps all-ones->0.
//  - err_cnt: +1 per err event, holds at 2^ERRW-1. clr_err has priority: clr and err same
//    edge -> err_cnt=0.
//  - rst mid-operation: overrides everything on that edge; next sample treated as first.
// TESTING (W=4, LOCK_CNT=4, ERRW=4)
//  1 rst 2 cycles, then 0000,0001,...,1000,0000 -> phase 0..7,0; phase_oh 01,02,..,80,01 one
//    edge later; locked=1 after edge sampling 1111; wrap pulse and rev_cnt=1 after final 0000.
//  2 Locked, inject 0101 -> code_err=1, phase_oh=00, err_cnt=1, locked=0 same edge; resume
//    0111,1111,1110,1100,1000 -> relock after 4 good transitions.
//  3 Locked at 0011, drive 1111 -> seq_err=1, err_cnt+1, locked=0; 1111 still decoded phase=4.
//  4 Hold cnt=0000 for 10 cycles after reset (upstream in reset) -> no errors, locked=0, run=0;
//    hold 0111 3 cycles while locked -> locked stays 1, no pulses.
//  5 Drive 20 consecutive illegal codes -> err_cnt saturates 15; clr_err with code_err same
//    edge -> err_cnt=0.
//  6 rst asserted mid-sequence while locked -> next edge all outputs 0; first sample after
//    release produces no seq_err regardless of value.

Source files
------------

// File: rtl/johnson_phase_monitor.sv
// johnson_phase_monitor
//   Watches the code of an upstream W-bit Johnson counter. Every clk it decodes the
//   sampled code to a phase index and a one-hot strobe, flags illegal codes and
//   out-of-order steps, tracks lock through a small FSM, and counts revolutions
//   and error cycles. All outputs are registered.
// Ports
//   clk      in   1     clock, rising edge
//   rst      in   1     synchronous active-high reset
//   cnt      in   W     Johnson code from the upstream counter
//   clr_err  in   1     synchronous clear of err_cnt (wins over a same-cycle error)
//   phase    out  PW    decoded phase index 0..2W-1 (0 on an illegal code)
//   phase_oh out  2W    one-hot phase, all zeros on an illegal code
//   code_err out  1     pulse: sampled code illegal
//   seq_err  out  1     pulse: legal code that is neither successor nor hold
//   wrap     out  1     pulse: good transition from phase 2W-1 to phase 0
//   locked   out  1     lock FSM is in LOCK
//   rev_cnt  out  REVW  wrap count, modulo 2^REVW
//   err_cnt  out  ERRW  error-cycle count, saturating
module johnson_phase_monitor #(
  parameter int unsigned W        = 4,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned REVW     = 8,
  parameter int unsigned ERRW     = 4,
  localparam int unsigned NS      = 2 * W,
  localparam int unsigned PW      = $clog2(NS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    cnt,
  input  logic            clr_err,
  output logic [PW-1:0]   phase,
  output logic [NS-1:0]   phase_oh,
  output logic            code_err,
  output logic            seq_err,
  output logic            wrap,
  output logic            locked,
  output logic [REVW-1:0] rev_cnt,
  output logic [ERRW-1:0] err_cnt
);

  localparam int unsigned RW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    S_UNLOCK = 2'd0,
    S_ACQ    = 2'd1,
    S_LOCK   = 2'd2
  } state_t;

  state_t        state;
  logic [RW-1:0] run;
  logic [W-1:0]  prev_code;
  logic          prev_valid;

  logic          legal;
  logic [PW-1:0] code_phase;
  logic [NS-1:0] code_oh;
  logic [W-1:0]  inv;
  logic [W-1:0]  succ;
  logic [PW-1:0] ones;
  logic          is_good;
  logic          is_hold;
  logic          is_seq;
  logic          is_wrap;
  logic          err_ev;
  logic [RW-1:0] run_inc;

  // Decode the sampled code and classify it against the previous legal code.
  always_comb begin
    legal      = 1'b0;
    code_phase = '0;
    code_oh    = '0;
    ones       = '0;
    inv        = ~cnt;
    succ       = {prev_code[W-2:0], ~prev_code[W-1]};
    for (int i = 0; i < int'(W); i++) begin
      ones = ones + PW'(cnt[i]);
    end
    // Contiguous-from-LSB run test: x & (x+1) is zero only for 0..01..1 patterns.
    if (!cnt[W-1]) begin
      legal      = ((cnt & (cnt + W'(1))) == '0);
      code_phase = ones;
    end else begin
      legal      = ((inv & (inv + W'(1))) == '0);
      // W + zeros == 2W - ones
      code_phase = PW'(NS) - ones;
    end
    if (!legal) begin
      code_phase = '0;
    end else begin
      code_oh = NS'(1) << code_phase;
    end
    is_good = prev_valid && legal && (cnt == succ);
    is_hold = prev_valid && legal && (cnt == prev_code);
    is_seq  = prev_valid && legal && !is_good && !is_hold;
    is_wrap = is_good && (code_phase == '0);
    err_ev  = !legal || is_seq;
    run_inc = run + RW'(1);
  end

  // Output registers, history, counters and lock FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= '0;
      phase_oh   <= '0;
      code_err   <= 1'b0;
      seq_err    <= 1'b0;
      wrap       <= 1'b0;
      locked     <= 1'b0;
      rev_cnt    <= '0;
      err_cnt    <= '0;
      state      <= S_UNLOCK;
      run        <= '0;
      prev_code  <= '0;
      prev_valid <= 1'b0;
    end else begin
      phase    <= code_phase;
      phase_oh <= code_oh;
      code_err <= !legal;
      seq_err  <= is_seq;
      wrap     <= is_wrap;

      if (legal) begin
        prev_code  <= cnt;
        prev_valid <= 1'b1;
      end else begin
        prev_valid <= 1'b0;
      end

      if (is_wrap) begin
        rev_cnt <= rev_cnt + REVW'(1);
      end

      if (clr_err) begin
        err_cnt <= '0;
      end else if (err_ev && (err_cnt != '1)) begin
        err_cnt <= err_cnt + ERRW'(1);
      end

      // Hold samples leave run and lock untouched in every state.
      case (state)
        S_UNLOCK: begin
          if (legal) begin
            state <= S_ACQ;
            run   <= '0;
          end
        end
        S_ACQ: begin
          if (err_ev) begin
            state <= S_UNLOCK;
            run   <= '0;
          end else if (is_good) begin
            run <= run_inc;
            if (run_inc == RW'(LOCK_CNT)) begin
              state  <= S_LOCK;
              locked <= 1'b1;
            end
          end
        end
        S_LOCK: begin
          if (err_ev) begin
            state  <= S_UNLOCK;
            run    <= '0;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= S_UNLOCK;
          run    <= '0;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Scoreboard bench for johnson_phase_monitor (W=4, LOCK_CNT=4, REVW=8, ERRW=4).
// The stimulus process drives one vector per cycle and queues its expected
// outputs; the monitor pops and compares after every rising edge.
module tb_johnson_phase_monitor;

  logic       clk;
  logic       rst;
  logic [3:0] cnt;
  logic       clr_err;
  logic [2:0] phase;
  logic [7:0] phase_oh;
  logic       code_err;
  logic       seq_err;
  logic       wrap;
  logic       locked;
  logic [7:0] rev_cnt;
  logic [3:0] err_cnt;

  johnson_phase_monitor #(
    .W(4), .LOCK_CNT(4), .REVW(8), .ERRW(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cnt      (cnt),
    .clr_err  (clr_err),
    .phase    (phase),
    .phase_oh (phase_oh),
    .code_err (code_err),
    .seq_err  (seq_err),
    .wrap     (wrap),
    .locked   (locked),
    .rev_cnt  (rev_cnt),
    .err_cnt  (err_cnt)
  );

  typedef struct {
    string      tag;
    logic [2:0] ph;
    logic [7:0] oh;
    logic       ce;
    logic       se;
    logic       wr;
    logic       lk;
    logic [7:0] rv;
    logic [3:0] er;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  string tag = "init";

  logic [3:0] codes [8];
  logic [3:0] ill   [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one sample and queue what the outputs must show after the next edge.
  task automatic v(input logic r, input logic c, input logic [3:0] code,
                   input logic [2:0] ph, input logic [7:0] oh,
                   input logic ce, input logic se, input logic wr, input logic lk,
                   input logic [7:0] rv, input logic [3:0] er);
    exp_t e;
    @(negedge clk);
    rst     = r;
    clr_err = c;
    cnt     = code;
    e.tag = tag; e.ph = ph; e.oh = oh; e.ce = ce; e.se = se;
    e.wr = wr; e.lk = lk; e.rv = rv; e.er = er;
    sb.push_back(e);
  endtask

  // Monitor: one registered result per cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if ({phase, phase_oh, code_err, seq_err, wrap, locked, rev_cnt, err_cnt} !==
            {e.ph, e.oh, e.ce, e.se, e.wr, e.lk, e.rv, e.er}) begin
          n_err++;
          $display("FAIL %s vec%0d: got ph=%0d oh=%h ce=%b se=%b wr=%b lk=%b rev=%0d err=%0d, need ph=%0d oh=%h ce=%b se=%b wr=%b lk=%b rev=%0d err=%0d",
                   e.tag, n_vec, phase, phase_oh, code_err, seq_err, wrap, locked, rev_cnt, err_cnt,
                   e.ph, e.oh, e.ce, e.se, e.wr, e.lk, e.rv, e.er);
        end
      end
    end
  end

  initial begin
    logic [7:0] rv;
    logic [3:0] er;
    logic [2:0] pp;
    logic [7:0] oh;
    rst = 1'b1; clr_err = 1'b0; cnt = 4'b0000;
    codes[0] = 4'b0000; codes[1] = 4'b0001; codes[2] = 4'b0011; codes[3] = 4'b0111;
    codes[4] = 4'b1111; codes[5] = 4'b1110; codes[6] = 4'b1100; codes[7] = 4'b1000;
    ill[0] = 4'b0101; ill[1] = 4'b1010; ill[2] = 4'b0010; ill[3] = 4'b0100;
    ill[4] = 4'b0110; ill[5] = 4'b1001; ill[6] = 4'b1011; ill[7] = 4'b1101;

    // 1: reset then one full revolution
    tag = "reset";
    v(1, 0, 4'b0000, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    v(1, 0, 4'b0000, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    tag = "rev1";
    v(0, 0, 4'b0000, 0, 8'h01, 0, 0, 0, 0, 0, 0);
    v(0, 0, 4'b0001, 1, 8'h02, 0, 0, 0, 0, 0, 0);
    v(0, 0, 4'b0011, 2, 8'h04, 0, 0, 0, 0, 0, 0);
    v(0, 0, 4'b0111, 3, 8'h08, 0, 0, 0, 0, 0, 0);
    v(0, 0, 4'b1111, 4, 8'h10, 0, 0, 0, 1, 0, 0);
    v(0, 0, 4'b1110, 5, 8'h20, 0, 0, 0, 1, 0, 0);
    v(0, 0, 4'b1100, 6, 8'h40, 0, 0, 0, 1, 0, 0);
    v(0, 0, 4'b1000, 7, 8'h80, 0, 0, 0, 1, 0, 0);
    v(0, 0, 4'b0000, 0, 8'h01, 0, 0, 1, 1, 1, 0);

    // 2: illegal code while locked, then relock
    tag = "code_err";
    v(0, 0, 4'b0001, 1, 8'h02, 0, 0, 0, 1, 1, 0);
    v(0, 0, 4'b0011, 2, 8'h04, 0, 0, 0, 1, 1, 0);
    v(0, 0, 4'b0101, 0, 8'h00, 1, 0, 0, 0, 1, 1);
    tag = "relock";
    v(0, 0, 4'b0111, 3, 8'h08, 0, 0, 0, 0, 1, 1);
    v(0, 0, 4'b1111, 4, 8'h10, 0, 0, 0, 0, 1, 1);
    v(0, 0, 4'b1110, 5, 8'h20, 0, 0, 0, 0, 1, 1);
    v(0, 0, 4'b1100, 6, 8'h40, 0, 0, 0, 0, 1, 1);
    v(0, 0, 4'b1000, 7, 8'h80, 0, 0, 0, 1, 1, 1);

    // 3: skipped step while locked
    tag = "seq_err";
    v(0, 0, 4'b0000, 0, 8'h01, 0, 0, 1, 1, 2, 1);
    v(0, 0, 4'b0001, 1, 8'h02, 0, 0, 0, 1, 2, 1);
    v(0, 0, 4'b0011, 2, 8'h04, 0, 0, 0, 1, 2, 1);
    v(0, 0, 4'b1111, 4, 8'h10, 0, 1, 0, 0, 2, 2);
    v(0, 0, 4'b1110, 5, 8'h20, 0, 0, 0, 0, 2, 2);
    v(0, 0, 4'b1110, 5, 8'h20, 0, 0, 0, 0, 2, 2);

    // 4: long hold after reset, then hold while locked
    tag = "hold_rst";
    v(1, 0, 4'b0000, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) v(0, 0, 4'b0000, 0, 8'h01, 0, 0, 0, 0, 0, 0);
    tag = "lock_after_hold";
    v(0, 0, 4'b0001, 1, 8'h02, 0, 0, 0, 0, 0, 0);
    v(0, 0, 4'b0011, 2, 8'h04, 0, 0, 0, 0, 0, 0);
    v(0, 0, 4'b0111, 3, 8'h08, 0, 0, 0, 0, 0, 0);
    v(0, 0, 4'b1111, 4, 8'h10, 0, 0, 0, 1, 0, 0);
    v(0, 0, 4'b1110, 5, 8'h20, 0, 0, 0, 1, 0, 0);
    v(0, 0, 4'b1100, 6, 8'h40, 0, 0, 0, 1, 0, 0);
    v(0, 0, 4'b1000, 7, 8'h80, 0, 0, 0, 1, 0, 0);
    v(0, 0, 4'b0000, 0, 8'h01, 0, 0, 1, 1, 1, 0);
    v(0, 0, 4'b0001, 1, 8'h02, 0, 0, 0, 1, 1, 0);
    v(0, 0, 4'b0011, 2, 8'h04, 0, 0, 0, 1, 1, 0);
    v(0, 0, 4'b0111, 3, 8'h08, 0, 0, 0, 1, 1, 0);
    tag = "hold_locked";
    for (int i = 0; i < 3; i++) v(0, 0, 4'b0111, 3, 8'h08, 0, 0, 0, 1, 1, 0);
    v(0, 0, 4'b1111, 4, 8'h10, 0, 0, 0, 1, 1, 0);

    // 5: saturate err_cnt, then clear in the same cycle as an error
    tag = "err_sat";
    for (int i = 0; i < 20; i++) begin
      er = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
      v(0, 0, ill[i % 8], 0, 8'h00, 1, 0, 0, 0, 1, er);
    end
    tag = "clr_vs_err";
    v(0, 1, 4'b0101, 0, 8'h00, 1, 0, 0, 0, 1, 0);
    v(0, 0, 4'b0000, 0, 8'h01, 0, 0, 0, 0, 1, 0);

    // 6: reset while locked; first sample afterwards is never a sequence error
    tag = "lock6";
    v(0, 0, 4'b0001, 1, 8'h02, 0, 0, 0, 0, 1, 0);
    v(0, 0, 4'b0011, 2, 8'h04, 0, 0, 0, 0, 1, 0);
    v(0, 0, 4'b0111, 3, 8'h08, 0, 0, 0, 0, 1, 0);
    v(0, 0, 4'b1111, 4, 8'h10, 0, 0, 0, 1, 1, 0);
    v(0, 0, 4'b1110, 5, 8'h20, 0, 0, 0, 1, 1, 0);
    tag = "mid_rst";
    v(1, 0, 4'b1100, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    tag = "first_after_rst";
    v(0, 0, 4'b0011, 2, 8'h04, 0, 0, 0, 0, 0, 0);
    v(0, 0, 4'b0111, 3, 8'h08, 0, 0, 0, 0, 0, 0);
    v(0, 0, 4'b1111, 4, 8'h10, 0, 0, 0, 0, 0, 0);
    v(0, 0, 4'b1110, 5, 8'h20, 0, 0, 0, 0, 0, 0);
    v(0, 0, 4'b1100, 6, 8'h40, 0, 0, 0, 1, 0, 0);
    v(0, 0, 4'b1000, 7, 8'h80, 0, 0, 0, 1, 0, 0);
    v(0, 0, 4'b0000, 0, 8'h01, 0, 0, 1, 1, 1, 0);

    // rev_cnt wraps from 255 back to 0 over 256 further revolutions
    tag = "rev_wrap";
    rv = 8'd1;
    for (int k = 0; k < 256; k++) begin
      for (int p = 1; p <= 8; p++) begin
        pp = 3'(p % 8);
        if (pp == 3'd0) rv = rv + 8'd1;
        oh = 8'h01 << pp;
        v(0, 0, codes[pp], pp, oh, 0, 0, (pp == 3'd0), 1, rv, 0);
      end
    end

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results outstanding, need 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
